instr_dispatcher: RTL and testbench
===================================

Name: instr_dispatcher

Overview:
- Sits directly downstream of the task scheduler, between it and the CORE_NUM compute cores.
- Accepts a task header (core mask, frame count) and pulls the task's instruction words from the scheduler with the core_reading handshake.
- Buffers those words in a small FIFO and broadcasts each word to every core in the task mask, advancing only when all masked cores have acknowledged it.
- Reports task completion once every masked core signals ready again.

Parameters:
- CORE_NUM, 16, number of cores and width of all mask ports
- INSTR_SIZE, 16, instruction word width
- FRAME_SIZE, 16, words per instruction frame
- FIFO_DEPTH, 8, word buffer entries; power of two, at least 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- task_start  in  1  one-cycle pulse: scheduler issued a task header
- task_mask  in  CORE_NUM  cores executing the task; sampled on task_start
- task_if_num  in  6  number of instruction frames; sampled on task_start
- core_reading  out  1  request one word from the scheduler
- instr_valid  in  1  requested word present, exactly 1 cycle after core_reading
- instr_data  in  INSTR_SIZE  instruction word
- core_instr  out  INSTR_SIZE  broadcast word, equal to the FIFO head
- core_instr_valid  out  1  core_instr valid
- core_sel  out  CORE_NUM  cores addressed by core_instr; equals the latched mask while valid, else 0
- core_ack  in  CORE_NUM  per-core word acceptance, level
- core_ready  in  CORE_NUM  per-core idle/finished, level
- busy  out  1  dispatcher not IDLE
- task_done  out  1  one-cycle completion pulse
- err_overrun  out  1  sticky: unexpected instr_valid or FIFO overflow

Behaviour:
- Reset (async): state IDLE, FIFO empty, all counters 0; every output 0.
- States: IDLE, FETCH, DRAIN, WAIT_DONE.
- IDLE:
  - On task_start, latch mask and words_left = task_if_num*FRAME_SIZE (10 bits, max 1008).
  - If words_left is 0, go to WAIT_DONE; otherwise go to FETCH.
  - task_start is ignored (no effect) in every other state.
- FETCH:
  - core_reading = (words_left != 0) && (fifo_count + inflight < FIFO_DEPTH), where inflight is the core_reading registered 1 cycle earlier.
  - Each asserted core_reading decrements words_left.
  - instr_valid pushes instr_data.
  - Leave for DRAIN when words_left is 0 and nothing is in flight.
- Broadcast, active in FETCH and DRAIN:
  - core_instr_valid = FIFO not empty; core_sel = mask.
  - ack_acc accumulates core_ack & mask.
  - The head pops in the cycle where (ack_acc | core_ack) & mask == mask; ack_acc then clears.
  - Acks from unmasked cores are ignored.
  - Push and pop in the same cycle are legal; fifo_count is unchanged.
  - A pop makes the next word visible on the following cycle, so throughput is 1 word/cycle when all cores ack immediately.
- DRAIN: when the FIFO is empty, go to WAIT_DONE.
- WAIT_DONE: when (core_ready & mask) == mask, pulse task_done for 1 cycle and go to IDLE. A zero mask completes immediately.
- err_overrun:
  - Set when instr_valid arrives with no request in flight; the word is dropped.
  - Set on a push to a full FIFO; the push is dropped.
  - Cleared only by reset.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; fifo_count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-task clears everything immediately; no partial-task recovery.

Decomposition:
- Shared package gpu_def: the state encoding (2-bit localparams) and the FRAME_SIZE / if_num width constants used by the scheduler.
- One natural sub-module: sync_fifo (push/pop/full/empty/count, parameterised width and depth). The dispatcher instantiates it once.

Test Plan:
- Single frame, all cores ack immediately: task_start with mask=16'h000F, if_num=1; cores ack the same cycle → exactly 16 core_reading pulses, 16 words broadcast in order at ~1/cycle. Raising core_ready[3:0] afterwards → task_done 1 cycle later, busy drops.
- Staggered acks: mask=16'h0003; core0 acks at cycle t, core1 at t+3 → head pops only at t+3. core_reading stalls after FIFO_DEPTH outstanding words; no word is lost or duplicated.
- Zero-frame task: if_num=0, mask=16'h0100 with core_ready[8]=0 → no core_reading. Setting core_ready[8]=1 → task_done pulse.
- Ignored header: task_start while in FETCH with a different mask → latched mask unchanged; the original task completes normally.
- Errors: instr_valid with no request in flight → err_overrun=1, FIFO count unchanged, err_overrun stays 1 until reset.
- Reset mid-task: assert reset in FETCH with 5 words buffered → all outputs 0 immediately. A new task afterwards runs cleanly from an empty FIFO.

Source files
------------

// File: rtl/gpu_def.sv
// Shared GPU definitions used by the task scheduler and the instruction
// dispatcher: the dispatcher state encoding, the instruction frame size and
// the widths of the frame count and the per-task word count.
package gpu_def;

  // Dispatcher state encoding (2 bits)
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_FETCH     = 2'd1;
  localparam logic [1:0] ST_DRAIN     = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_FETCH     = ST_FETCH,
    S_DRAIN     = ST_DRAIN,
    S_WAIT_DONE = ST_WAIT_DONE
  } disp_state_t;

  localparam int GPU_FRAME_SIZE = 16;  // words per instruction frame
  localparam int GPU_IF_NUM_W   = 6;   // width of the frame count field
  localparam int GPU_WORDS_W    = 10;  // width of a task's word count (max 63*16)

  // Total number of instruction words carried by a task header.
  function automatic logic [GPU_WORDS_W-1:0] frames_to_words(
    input logic [GPU_IF_NUM_W-1:0] if_num,
    input int                      frame_size
  );
    return GPU_WORDS_W'(if_num) * GPU_WORDS_W'(frame_size);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output.
// Ports:
//   clk, reset       clock, asynchronous active-high reset (pointers/count)
//   push, push_data  write request and data; dropped when full
//   pop              remove the head entry; ignored when empty
//   head             current head entry (valid while !empty)
//   full, empty      occupancy flags
//   count            number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits and wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/instr_dispatcher.sv
// Instruction dispatcher: takes a task header from the scheduler, pulls the
// task's instruction words through the core_reading/instr_valid handshake,
// buffers them and broadcasts each word to every core in the task mask.
// A word retires once all masked cores have acknowledged it (acks may arrive
// in different cycles). The task completes once all masked cores are ready.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   task_start/task_mask/
//   task_if_num                   task header, sampled in IDLE only
//   core_reading                  one-word request to the scheduler
//   instr_valid/instr_data        requested word, one cycle after the request
//   core_instr/core_instr_valid/
//   core_sel                      broadcast word and addressed cores
//   core_ack                      per-core word acceptance (level)
//   core_ready                    per-core idle/finished (level)
//   busy                          dispatcher not idle
//   task_done                     one-cycle completion pulse
//   err_overrun                   sticky: unexpected word or FIFO overflow
module instr_dispatcher
  import gpu_def::*;
#(
  parameter int CORE_NUM   = 16,
  parameter int INSTR_SIZE = 16,
  parameter int FRAME_SIZE = GPU_FRAME_SIZE,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    task_start,
  input  logic [CORE_NUM-1:0]     task_mask,
  input  logic [GPU_IF_NUM_W-1:0] task_if_num,
  output logic                    core_reading,
  input  logic                    instr_valid,
  input  logic [INSTR_SIZE-1:0]   instr_data,
  output logic [INSTR_SIZE-1:0]   core_instr,
  output logic                    core_instr_valid,
  output logic [CORE_NUM-1:0]     core_sel,
  input  logic [CORE_NUM-1:0]     core_ack,
  input  logic [CORE_NUM-1:0]     core_ready,
  output logic                    busy,
  output logic                    task_done,
  output logic                    err_overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);

  disp_state_t            state_reg, state_next;
  logic [CORE_NUM-1:0]    mask_reg, mask_next;
  logic [CORE_NUM-1:0]    ack_acc_reg, ack_acc_next;
  logic [GPU_WORDS_W-1:0] words_left_reg, words_left_next;
  logic [GPU_WORDS_W-1:0] header_words;
  logic                   inflight_reg;
  logic                   err_reg, err_next;
  logic                   done_reg, done_next;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [INSTR_SIZE-1:0]  fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [AW:0]            fifo_count;
  logic [AW+1:0]          occupancy;

  logic                   reading;
  logic                   head_valid;
  logic [CORE_NUM-1:0]    ack_hit;
  logic [CORE_NUM-1:0]    ready_hit;
  logic                   all_ack;
  logic                   all_ready;

  // A core counts as satisfied when it is outside the mask, or when it has
  // acked (earlier in this word, or right now) / is ready.
  genvar gi;
  generate
    for (gi = 0; gi < CORE_NUM; gi++) begin : g_core
      assign ack_hit[gi]   = !mask_reg[gi] || ack_acc_reg[gi] || core_ack[gi];
      assign ready_hit[gi] = !mask_reg[gi] || core_ready[gi];
    end
  endgenerate

  assign all_ack   = &ack_hit;
  assign all_ready = &ready_hit;

  // Only a requested word is stored; anything else is an overrun.
  assign fifo_push    = instr_valid && inflight_reg;
  assign header_words = frames_to_words(task_if_num, FRAME_SIZE);
  // Words buffered plus the word still on its way from the scheduler.
  assign occupancy    = {1'b0, fifo_count} + {{(AW+1){1'b0}}, inflight_reg};

  sync_fifo #(
    .WIDTH (INSTR_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (instr_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      mask_reg       <= '0;
      ack_acc_reg    <= '0;
      words_left_reg <= '0;
      inflight_reg   <= 1'b0;
      err_reg        <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mask_reg       <= mask_next;
      ack_acc_reg    <= ack_acc_next;
      words_left_reg <= words_left_next;
      inflight_reg   <= reading;
      err_reg        <= err_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    mask_next       = mask_reg;
    ack_acc_next    = ack_acc_reg;
    words_left_next = words_left_reg;
    err_next        = err_reg;
    done_next       = 1'b0;
    reading         = 1'b0;
    fifo_pop        = 1'b0;
    head_valid      = 1'b0;

    // Broadcast of the FIFO head while the task is fetching or draining.
    if ((state_reg == S_FETCH) || (state_reg == S_DRAIN)) begin
      head_valid = !fifo_empty;
    end
    if (head_valid) begin
      if (all_ack) begin
        fifo_pop     = 1'b1;
        ack_acc_next = '0;
      end else begin
        ack_acc_next = ack_acc_reg | (core_ack & mask_reg);
      end
    end

    if ((instr_valid && !inflight_reg) || (fifo_push && fifo_full)) begin
      err_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (task_start) begin
          mask_next       = task_mask;
          words_left_next = header_words;
          ack_acc_next    = '0;
          state_next      = (header_words == '0) ? S_WAIT_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        reading = (words_left_reg != '0) && (occupancy < (AW+2)'(FIFO_DEPTH));
        if (reading) begin
          words_left_next = words_left_reg - 1'b1;
        end
        if ((words_left_reg == '0) && !inflight_reg) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (all_ready) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign core_reading     = reading;
  assign core_instr_valid = head_valid;
  // Gate the head so the broadcast bus reads 0 whenever nothing is valid.
  assign core_instr       = head_valid ? fifo_head : '0;
  assign core_sel         = head_valid ? mask_reg : '0;
  assign busy             = (state_reg != S_IDLE);
  assign task_done        = done_reg;
  assign err_overrun      = err_reg;

endmodule

// File: tb/tb_instr_dispatcher.sv
module tb_instr_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        task_start;
  logic [15:0] task_mask;
  logic [5:0]  task_if_num;
  logic        core_reading;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = 16'h0;
  logic [15:0] core_instr;
  logic        core_instr_valid;
  logic [15:0] core_sel;
  logic [15:0] core_ack = 16'h0;
  logic [15:0] core_ready;
  logic        busy;
  logic        task_done;
  logic        err_overrun;

  always #5 clk = ~clk;

  instr_dispatcher #(
    .CORE_NUM   (16),
    .INSTR_SIZE (16),
    .FRAME_SIZE (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .task_start       (task_start),
    .task_mask        (task_mask),
    .task_if_num      (task_if_num),
    .core_reading     (core_reading),
    .instr_valid      (instr_valid),
    .instr_data       (instr_data),
    .core_instr       (core_instr),
    .core_instr_valid (core_instr_valid),
    .core_sel         (core_sel),
    .core_ack         (core_ack),
    .core_ready       (core_ready),
    .busy             (busy),
    .task_done        (task_done),
    .err_overrun      (err_overrun)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: words supplied by the scheduler model, in order.
  logic [15:0] exp_q[$];
  logic [15:0] exp_mask   = 16'h0;
  logic        req_s      = 1'b0;
  logic        inject_req = 1'b0;
  int          supplied   = 0;
  int          reads      = 0;
  int          popped     = 0;
  int          valid_cyc  = 0;
  int          out_max    = 0;
  logic [15:0] acc_m      = 16'h0;
  int          ack_mode   = 0;
  logic [15:0] ack_const  = 16'h0;

  function automatic logic [15:0] word_of(input int n);
    logic [15:0] w;
    w = 16'h5A00 ^ 16'(n * 16'h0123);
    return w;
  endfunction

  // Scheduler model: answers each request with the next word one cycle later.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      instr_valid = 1'b0;
      instr_data  = 16'h0;
    end else begin
      instr_valid = req_s || inject_req;
      if (req_s) begin
        instr_data = word_of(supplied);
        exp_q.push_back(instr_data);
        supplied++;
      end else begin
        instr_data = inject_req ? 16'hDEAD : 16'h0;
      end
    end
  end

  // Core ack model: constant level, or staggered (core0 at k=0, core1 at k=3,
  // unmasked core2 acking all the time).
  always @(posedge clk) begin
    int k;
    #1;
    if (ack_mode == 1) begin
      if (core_instr_valid) begin
        core_ack = 16'h0004 | ((k == 0) ? 16'h0001 : 16'h0) | ((k == 3) ? 16'h0002 : 16'h0);
        k = (k == 3) ? 0 : k + 1;
      end else begin
        core_ack = 16'h0004;
        k = 0;
      end
    end else begin
      core_ack = ack_const;
      k = 0;
    end
  end

  // Monitor: samples requests and checks every broadcast cycle.
  always @(negedge clk) begin
    req_s = core_reading && !reset;
    if (core_reading && !reset) reads++;
    if (reset) begin
      exp_q.delete();
      acc_m = 16'h0;
    end else if (core_instr_valid) begin
      valid_cyc++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %0h, expected no word", core_instr);
      end else begin
        check("core_instr", core_instr, exp_q[0]);
        check("core_sel", core_sel, exp_mask);
        acc_m = acc_m | (core_ack & exp_mask);
        if (acc_m == exp_mask) begin
          $display("word %0d: %04h sel=%04h", popped, core_instr, core_sel);
          void'(exp_q.pop_front());
          acc_m = 16'h0;
          popped++;
        end
      end
    end
    if (!reset && (reads - popped) > out_max) out_max = reads - popped;
  end

  task automatic start_task(input logic [15:0] m, input logic [5:0] n);
    @(posedge clk); #1;
    task_start  = 1'b1;
    task_mask   = m;
    task_if_num = n;
    @(posedge clk); #1;
    task_start  = 1'b0;
    $display("task_start mask=%04h if_num=%0d", m, n);
  endtask

  task automatic wait_popped(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (popped >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_words: got %0d words, expected %0d", popped, target);
    end
  endtask

  task automatic ready_and_done(input logic [15:0] rdy);
    @(posedge clk); #1;
    core_ready = rdy;
    @(negedge clk); #1;
    check("done_early", task_done, 0);
    check("busy_before_done", busy, 1);
    @(negedge clk); #1;
    check("task_done", task_done, 1);
    check("busy_after_done", busy, 0);
    @(negedge clk); #1;
    check("done_pulse_width", task_done, 0);
    $display("task_done seen, ready=%04h", rdy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core_reading"}, core_reading, 0);
    check({tag, "_core_instr_valid"}, core_instr_valid, 0);
    check({tag, "_core_sel"}, core_sel, 0);
    check({tag, "_core_instr"}, core_instr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_task_done"}, task_done, 0);
    check({tag, "_err_overrun"}, err_overrun, 0);
  endtask

  initial begin
    int r0, p0, v0, s0;
    reset       = 1'b1;
    task_start  = 1'b0;
    task_mask   = 16'h0;
    task_if_num = 6'd0;
    core_ready  = 16'h0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    // Single frame, immediate acks.
    exp_mask = 16'h000F; ack_const = 16'h000F; core_ready = 16'h0;
    r0 = reads; p0 = popped; v0 = valid_cyc;
    start_task(16'h000F, 6'd1);
    wait_popped(p0 + 16, 200);
    check("t1_reads", reads - r0, 16);
    check("t1_valid_cycles", valid_cyc - v0, 16);
    repeat (3) @(negedge clk);
    check("t1_busy_wait", busy, 1);
    ready_and_done(16'h000F);

    // Staggered acks, FIFO fills to its depth.
    core_ready = 16'h0; exp_mask = 16'h0003; ack_mode = 1;
    r0 = reads; p0 = popped; v0 = valid_cyc;
    start_task(16'h0003, 6'd1);
    wait_popped(p0 + 16, 400);
    check("t2_reads", reads - r0, 16);
    check("t2_valid_cycles", valid_cyc - v0, 64);
    check("t2_max_outstanding", out_max, 8);
    repeat (3) @(negedge clk);
    ready_and_done(16'h0003);
    ack_mode = 0;

    // Zero-frame task.
    core_ready = 16'h0; exp_mask = 16'h0100;
    r0 = reads;
    start_task(16'h0100, 6'd0);
    repeat (5) @(negedge clk);
    #1;
    check("t3_reads", reads - r0, 0);
    check("t3_busy", busy, 1);
    check("t3_no_done", task_done, 0);
    core_ready = 16'hFEFF;
    repeat (3) @(negedge clk);
    #1;
    check("t3_partial_ready_busy", busy, 1);
    ready_and_done(16'h0100);

    // Header while fetching is ignored.
    core_ready = 16'h0; exp_mask = 16'h000F; ack_const = 16'h000F;
    r0 = reads; p0 = popped;
    start_task(16'h000F, 6'd1);
    repeat (2) @(posedge clk);
    start_task(16'h00F0, 6'd2);
    wait_popped(p0 + 16, 200);
    repeat (5) @(negedge clk);
    #1;
    check("t4_reads", reads - r0, 16);
    check("t4_words", popped - p0, 16);
    ready_and_done(16'h000F);

    // Unrequested word sets the sticky error and is not stored.
    core_ready = 16'h0;
    check("t5_err_before", err_overrun, 0);
    @(negedge clk); #1 inject_req = 1'b1;
    @(negedge clk); #1 inject_req = 1'b0;
    @(negedge clk); #1;
    check("t5_err_set", err_overrun, 1);
    check("t5_fifo_empty", core_instr_valid, 0);
    p0 = popped;
    start_task(16'h000F, 6'd1);
    wait_popped(p0 + 16, 200);
    repeat (3) @(negedge clk);
    ready_and_done(16'h000F);
    check("t5_err_sticky", err_overrun, 1);

    // Reset with words buffered.
    core_ready = 16'h0; exp_mask = 16'h0003; ack_const = 16'h0;
    s0 = supplied;
    start_task(16'h0003, 6'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (supplied - s0 >= 6) break;
    end
    check("t6_supplied", supplied - s0, 6);
    check("t6_valid_before", core_instr_valid, 1);
    #1 reset = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    exp_mask = 16'h0001; ack_const = 16'h0001;
    r0 = reads; p0 = popped;
    start_task(16'h0001, 6'd1);
    wait_popped(p0 + 16, 200);
    check("t6_reads_after", reads - r0, 16);
    repeat (3) @(negedge clk);
    ready_and_done(16'h0001);
    check("t6_err_clear", err_overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
